// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, with a small byte FIFO in front of it.
// Line, active and done outputs are registered from the FSM state, so each one lags the state by a cycle.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5207,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;

    logic          push;
    logic          pop;
    logic          full;

    assign full = (count_q == DEPTH_C);
    assign push = i_Tx_DV && !full;

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // Full is judged before any same-cycle pop, so a push at full is always dropped.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= i_Tx_DV && full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
                if (clk_cnt_q == CNT_MAX) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                serial_d = shift_q[bit_idx_q];
                active_d = 1'b1;
                if (clk_cnt_q == CNT_MAX) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                active_d = 1'b1;
                if (clk_cnt_q == CNT_MAX) begin
                    clk_cnt_d = '0;
                    state_d   = S_CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_CLEANUP: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign o_Tx_Ready   = !full;
    assign o_Overflow   = overflow_q;
    assign o_Fifo_Count = count_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLKS_PER_BIT=8, FIFO_DEPTH=4: scenario tasks plus a
// serial-line monitor that decodes frames and checks them against a byte scoreboard.
module tb_uart_tx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] txb;
    logic       ready;
    logic       ovf;
    logic [2:0] cnt;
    logic       ser;
    logic       act;
    logic       done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ovf_cnt = 0;
    int frame_cnt = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Tx_DV     (dv),
        .i_Tx_Byte   (txb),
        .o_Tx_Ready  (ready),
        .o_Overflow  (ovf),
        .o_Fifo_Count(cnt),
        .o_Tx_Serial (ser),
        .o_Tx_Active (act),
        .o_Tx_Done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (ovf === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    // Frame monitor: c=0 is the first low sample; c=80 must be the Done cycle.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] expb;
        logic       bad;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ser === 1'b0) begin
                start_q.push_back(cyc);
                bad = 1'b0;
                aborted = 1'b0;
                got = 8'h00;
                for (int c = 0; c <= 80; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c < 8) begin
                        if (ser !== 1'b0 || act !== 1'b1 || done !== 1'b0) bad = 1'b1;
                    end else if (c < 72) begin
                        if (act !== 1'b1 || done !== 1'b0) bad = 1'b1;
                        if (((c - 8) % 8) == 0) got[(c - 8) / 8] = ser;
                        else if (ser !== got[(c - 8) / 8]) bad = 1'b1;
                    end else if (c < 80) begin
                        if (ser !== 1'b1 || act !== 1'b1 || done !== 1'b0) bad = 1'b1;
                    end else begin
                        if (ser !== 1'b1 || act !== 1'b0 || done !== 1'b1) bad = 1'b1;
                    end
                end
                if (!aborted) begin
                    frame_cnt++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL frame: received %h but no byte was expected", got);
                    end else begin
                        expb = exp_q.pop_front();
                        if (bad || got !== expb) begin
                            fails++;
                            $display("FAIL frame: received %h (framing_bad=%0b), required %h", got, bad, expb);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (frame_cnt < target) begin
            fails++;
            $display("FAIL wait_frames: got %0d frames, required %0d", frame_cnt, target);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv  = 1'b0;
        txb = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (ser !== 1'b1) begin fails++; $display("FAIL reset_serial: got %b, required 1", ser); end
        tests++; if (act !== 1'b0) begin fails++; $display("FAIL reset_active: got %b, required 0", act); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", ovf); end
        tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d, required 0", cnt); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int f0 = frame_cnt;
        int bad_low = -1;
        int bad_act = -1;
        int bad_done = -1;
        logic want;
        exp_q.push_back(8'hA5);
        dv  = 1'b1;
        txb = 8'hA5;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            if (k <= 10) begin
                want = !(k >= 2 && k <= 9);
                if (ser !== want && bad_low < 0) bad_low = k;
            end
            want = (k >= 2 && k <= 81);
            if (act !== want && bad_act < 0) bad_act = k;
            want = (k == 82);
            if (done !== want && bad_done < 0) bad_done = k;
        end
        tests++; if (bad_low >= 0) begin fails++; $display("FAIL single_start: line wrong at cycle %0d, required low for cycles 2-9", bad_low); end
        tests++; if (bad_act >= 0) begin fails++; $display("FAIL single_active: active wrong at cycle %0d, required high for cycles 2-81", bad_act); end
        tests++; if (bad_done >= 0) begin fails++; $display("FAIL single_done: done wrong at cycle %0d, required pulse at cycle 82", bad_done); end
        wait_frames(f0 + 1, 200);
    endtask

    task automatic test_burst();
        int f0 = frame_cnt;
        int d0 = done_cnt;
        int s0 = start_q.size();
        int max_cnt = 0;
        logic ready_dropped = 1'b0;
        int bad_gap = -1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            dv  = 1'b1;
            txb = 8'(i);
            @(negedge clk);
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
            if (ready !== 1'b1) ready_dropped = 1'b1;
        end
        dv = 1'b0;
        tests++; if (max_cnt != 3) begin fails++; $display("FAIL burst_count_peak: got %0d, required 3", max_cnt); end
        tests++; if (ready_dropped) begin fails++; $display("FAIL burst_ready: got 0 during burst, required 1"); end
        wait_frames(f0 + 4, 600);
        for (int i = 1; i < 4; i++) begin
            if (start_q.size() >= s0 + 4 && start_q[s0 + i] - start_q[s0 + i - 1] != 82 && bad_gap < 0)
                bad_gap = start_q[s0 + i] - start_q[s0 + i - 1];
        end
        tests++; if (start_q.size() < s0 + 4 || bad_gap >= 0) begin fails++; $display("FAIL burst_spacing: start-to-start %0d cycles, required 82", bad_gap); end
        tests++; if (done_cnt - d0 != 4) begin fails++; $display("FAIL burst_done: got %0d pulses, required 4", done_cnt - d0); end
    endtask

    task automatic test_overflow();
        int f0 = frame_cnt;
        int o0 = ovf_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'hC0 + 8'(i));
            dv  = 1'b1;
            txb = 8'hC0 + 8'(i);
            @(negedge clk);
            if (i == 4) begin
                tests++; if (cnt !== 3'd4) begin fails++; $display("FAIL ovf_count_full: got %0d, required 4", cnt); end
                tests++; if (ready !== 1'b0) begin fails++; $display("FAIL ovf_ready: got %b, required 0", ready); end
                tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b, required 0", ovf); end
            end
        end
        dv = 1'b0;
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %b, required 1", ovf); end
        @(negedge clk);
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_pulse_width: got %b, required 0", ovf); end
        repeat (3) @(negedge clk);
        dv  = 1'b1;
        txb = 8'hEE;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        tests++; if (ovf_cnt - o0 != 2) begin fails++; $display("FAIL ovf_pulse_count: got %0d, required 2", ovf_cnt - o0); end
        wait_frames(f0 + 5, 800);
        tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL ovf_drain: count %0d, required 0", cnt); end
    endtask

    task automatic test_push_pop();
        int f0 = frame_cnt;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        dv = 1'b1; txb = 8'h10;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        dv = 1'b1; txb = 8'h20;
        @(negedge clk);
        txb = 8'h30;
        @(negedge clk);
        dv = 1'b0;
        repeat (79) @(negedge clk);
        tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL pushpop_before: count %0d, required 2", cnt); end
        dv = 1'b1; txb = 8'h40;
        @(negedge clk);
        dv = 1'b0;
        tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL pushpop_same_cycle: count %0d, required 2", cnt); end
        wait_frames(f0 + 4, 600);
    endtask

    task automatic test_reset_mid();
        int f0 = frame_cnt;
        int d0 = done_cnt;
        int high_bad = 0;
        dv = 1'b1; txb = 8'hFF;
        @(negedge clk);
        txb = 8'h11;
        @(negedge clk);
        txb = 8'h22;
        @(negedge clk);
        dv = 1'b0;
        repeat (34) @(negedge clk);
        tests++; if (act !== 1'b1 || ser !== 1'b1) begin fails++; $display("FAIL midframe_bit3: active=%b line=%b, required 1/1", act, ser); end
        tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL midframe_queued: count %0d, required 2", cnt); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (ser !== 1'b1) begin fails++; $display("FAIL abort_line: got %b, required 1", ser); end
        tests++; if (act !== 1'b0) begin fails++; $display("FAIL abort_active: got %b, required 0", act); end
        tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL abort_count: got %0d, required 0", cnt); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b, required 1", ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ser !== 1'b1) high_bad++;
        end
        tests++; if (high_bad != 0) begin fails++; $display("FAIL abort_quiet: line low %0d cycles, required 0", high_bad); end
        tests++; if (done_cnt != d0) begin fails++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0); end
        tests++; if (frame_cnt != f0) begin fails++; $display("FAIL abort_no_frames: got %0d frames, required 0", frame_cnt - f0); end
    endtask

    initial begin
        rst = 1'b1;
        dv  = 1'b0;
        txb = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_pop();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d bytes never sent, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
